// File: rtl/mem_access_unit.sv
// Load/store unit between EXU and WBU: aligns requests to the data bus, builds
// byte strobes, extracts and extends load data, and aborts stalled accesses.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_ren,
    input  logic                  in_wen,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [DATA_W-1:0]     in_alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t             state, state_nxt;
    logic [1:0]         size_q;
    logic               signed_q;
    logic               is_load_q;
    logic [OFF_W-1:0]   off_q;
    logic [CNT_W-1:0]   cnt;

    logic               mem_op;
    logic               misaligned;
    logic [2:0]         align_mask;
    logic [STRB_W-1:0]  strb_base;
    logic [OFF_W-1:0]   in_off;
    logic               timeout_hit;
    logic [DATA_W-1:0]  resp_shift;
    logic [DATA_W-1:0]  load_val;

    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign out_valid     = (state == OUT);

    assign mem_op      = in_ren | in_wen;
    assign in_off      = in_addr[OFF_W-1:0];
    assign timeout_hit = (TIMEOUT != 0) && (cnt >= CNT_LIMIT);

    always_comb begin
        align_mask = 3'b000;
        strb_base  = '0;
        case (in_size)
            2'b00: begin align_mask = 3'b000; strb_base = STRB_W'(4'h1); end
            2'b01: begin align_mask = 3'b001; strb_base = STRB_W'(4'h3); end
            2'b10: begin align_mask = 3'b011; strb_base = STRB_W'(4'hF); end
            default: begin align_mask = 3'b111; strb_base = '1; end
        endcase
    end

    // A double access has no meaning on a 32-bit bus, so it is reported like misalignment.
    assign misaligned = (|(in_addr[2:0] & align_mask)) || (in_size == 2'b11 && DATA_W == 32);

    assign resp_shift = mem_resp_data >> {off_q, 3'b000};

    always_comb begin
        load_val = '0;
        case (size_q)
            2'b00: load_val = signed_q ? DATA_W'($signed(resp_shift[7:0]))  : DATA_W'(resp_shift[7:0]);
            2'b01: load_val = signed_q ? DATA_W'($signed(resp_shift[15:0])) : DATA_W'(resp_shift[15:0]);
            2'b10: load_val = signed_q ? DATA_W'($signed(resp_shift[31:0])) : DATA_W'(resp_shift[31:0]);
            default: load_val = resp_shift;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_op || misaligned) state_nxt = OUT;
                    else                       state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready)    state_nxt = RESP;
                else if (timeout_hit) state_nxt = OUT;
            end
            RESP: begin
                if (mem_resp_valid || timeout_hit) state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Everything downstream of the accept cycle runs from these captured fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            size_q        <= '0;
            signed_q      <= 1'b0;
            is_load_q     <= 1'b0;
            off_q         <= '0;
            cnt           <= '0;
            out_data      <= '0;
            out_err       <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt       <= '0;
                        size_q    <= in_size;
                        signed_q  <= in_signed;
                        is_load_q <= in_ren & ~in_wen;
                        off_q     <= in_off;
                        if (!mem_op) begin
                            out_data <= in_alu_result;
                            out_err  <= 1'b0;
                        end else if (misaligned) begin
                            out_data <= '0;
                            out_err  <= 1'b1;
                        end else begin
                            mem_req_we    <= in_wen;
                            mem_req_addr  <= {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            mem_req_wdata <= in_wen ? (in_wdata << {in_off, 3'b000}) : '0;
                            mem_req_wstrb <= in_wen ? (strb_base << in_off) : '0;
                        end
                    end
                end
                REQ: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (!mem_req_ready && timeout_hit) begin
                        out_data <= '0;
                        out_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (mem_resp_valid) begin
                        out_data <= is_load_q ? load_val : '0;
                        out_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        out_data <= '0;
                        out_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (DATA_W=32, TIMEOUT=4): directed cases plus random
// transactions compared against a byte-level reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ren, in_wen, in_signed;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata, in_alu_result;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_data;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          req;
        bit          err;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          we;
    } exp_t;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size), .in_signed(in_signed),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_result(in_alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Reference: what the access should do, worked out byte by byte.
    function automatic exp_t model(input logic ren, input logic wen, input logic [1:0] size,
                                   input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] alu, input logic [31:0] rd);
        exp_t e;
        int nbytes, off;
        logic [63:0] v, full;
        e = '{default: 0};
        nbytes = 1 << size;
        off = int'(addr % 4);
        if (!ren && !wen) begin
            e.data = alu;
            return e;
        end
        if (size == 2'b11 || (addr % nbytes) != 0) begin
            e.err = 1;
            return e;
        end
        e.req  = 1;
        e.addr = addr - off;
        e.we   = wen;
        if (wen) begin
            e.wdata = wd << (8 * off);
            v = ((64'd1 << nbytes) - 1) << off;
            e.wstrb = v[3:0];
        end else begin
            full = 64'd1 << (8 * nbytes);
            v = ({32'd0, rd} >> (8 * off)) & (full - 1);
            if (sgn && v[8*nbytes-1]) v = v - full;
            e.data = v[31:0];
        end
        return e;
    endfunction

    task automatic do_txn(input string name, input logic ren, input logic wen, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] alu, input logic [31:0] rd,
                          input int rwait, input int dwait, input int owait);
        exp_t e;
        int exp_cyc, exp_reqs, cyc, req_cnt, resp_cnt, out_cnt, first_out;
        bit hs, done, timed_out;
        logic [31:0] c_addr, c_wdata, o_data;
        logic [3:0]  c_wstrb;
        logic        c_we, o_err;
        e = model(ren, wen, size, sgn, addr, wd, alu, rd);
        timed_out = e.req && (rwait + dwait + 1 > TO - 1);
        if (timed_out) begin
            e.err = 1;
            e.data = 0;
        end
        exp_cyc  = !e.req ? 1 : (timed_out ? TO + 1 : rwait + dwait + 3);
        exp_reqs = !e.req ? 0 : ((rwait + 1 < TO) ? rwait + 1 : TO);
        c_addr = 0; c_wdata = 0; c_wstrb = 0; c_we = 0; o_data = 0; o_err = 0;
        first_out = -1;

        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s idle_ready: got %b want 1", name, in_ready);
        end
        in_valid = 1; in_ren = ren; in_wen = wen; in_size = size; in_signed = sgn;
        in_addr = addr; in_wdata = wd; in_alu_result = alu;
        @(negedge clk);
        in_valid = 0;
        in_ren = 1'($urandom); in_wen = 1'($urandom); in_size = 2'($urandom);
        in_signed = 1'($urandom); in_addr = $urandom; in_wdata = $urandom; in_alu_result = $urandom;

        cyc = 1; req_cnt = 0; resp_cnt = 0; out_cnt = 0; hs = 0; done = 0;
        while (!done && cyc < 40) begin
            mem_req_ready = 0; mem_resp_valid = 0; out_ready = 0;
            if (out_valid) begin
                if (out_cnt == 0) begin
                    first_out = cyc; o_data = out_data; o_err = out_err;
                end else begin
                    checks++;
                    if (out_data !== o_data || out_err !== o_err || in_ready !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL %s out_hold: got %h/%b/%b want %h/%b/0",
                                 name, out_data, out_err, in_ready, o_data, o_err);
                    end
                end
                if (out_cnt >= owait) begin
                    out_ready = 1; done = 1;
                end
                out_cnt++;
            end else if (mem_req_valid) begin
                if (req_cnt == 0) begin
                    c_addr = mem_req_addr; c_wdata = mem_req_wdata; c_wstrb = mem_req_wstrb; c_we = mem_req_we;
                end else begin
                    checks++;
                    if (mem_req_addr !== c_addr || mem_req_wdata !== c_wdata ||
                        mem_req_wstrb !== c_wstrb || mem_req_we !== c_we) begin
                        errors++;
                        $display("[TB] FAIL %s req_hold: got %h/%h want %h/%h",
                                 name, mem_req_addr, mem_req_wdata, c_addr, c_wdata);
                    end
                end
                if (req_cnt >= rwait) begin
                    mem_req_ready = 1; hs = 1;
                end else begin
                    mem_resp_valid = 1'($urandom); mem_resp_data = $urandom;
                end
                req_cnt++;
            end else if (hs) begin
                if (resp_cnt >= dwait) begin
                    mem_resp_valid = 1; mem_resp_data = rd;
                end
                resp_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_req_ready = 0; mem_resp_valid = 0; out_ready = 0;

        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s completion: got no handshake in 40 cycles, want one", name);
        end
        checks++;
        if (first_out != exp_cyc) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, first_out, exp_cyc);
        end
        checks++;
        if (o_data !== e.data || o_err !== e.err) begin
            errors++;
            $display("[TB] FAIL %s result: got %h err=%b want %h err=%b", name, o_data, o_err, e.data, e.err);
        end
        checks++;
        if (req_cnt != exp_reqs) begin
            errors++;
            $display("[TB] FAIL %s req_cycles: got %0d want %0d", name, req_cnt, exp_reqs);
        end
        if (e.req) begin
            checks++;
            if (c_addr !== e.addr || c_wdata !== e.wdata || c_wstrb !== e.wstrb || c_we !== e.we) begin
                errors++;
                $display("[TB] FAIL %s req_fields: got %h/%h/%b/%b want %h/%h/%b/%b", name,
                         c_addr, c_wdata, c_wstrb, c_we, e.addr, e.wdata, e.wstrb, e.we);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s back_idle: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_data !== 32'd0 ||
            out_err !== 1'b0 || mem_req_addr !== 32'd0 || mem_req_wstrb !== 4'd0 || mem_req_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got rdy=%b ov=%b mv=%b d=%h e=%b a=%h want 1/0/0/0/0/0",
                     in_ready, out_valid, mem_req_valid, out_data, out_err, mem_req_addr);
        end
        rst = 0;
    endtask

    task automatic test_directed();
        do_txn("passthru", 0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 0, 0, 0);
        do_txn("lb_signed", 1, 0, 2'b00, 1, 32'h8000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 0, 0);
        do_txn("lbu", 1, 0, 2'b00, 0, 32'h8000_0003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 0, 0);
        do_txn("sh", 0, 1, 2'b01, 0, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 32'h0, 0, 0, 0);
        do_txn("rw_is_store", 1, 1, 2'b10, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 32'h1111_1111, 0, 0, 0);
        do_txn("lw_misalign", 1, 0, 2'b10, 0, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        do_txn("ld_on_32", 1, 0, 2'b11, 0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        do_txn("lh_signed", 1, 0, 2'b01, 1, 32'h0000_0002, 32'h0, 32'h0, 32'h9876_0000, 1, 1, 0);
    endtask

    task automatic test_timeout();
        do_txn("req_timeout", 1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 32'h0, 32'h5555_AAAA, 99, 0, 0);
        do_txn("resp_timeout", 0, 1, 2'b10, 0, 32'h0000_0104, 32'h1234_0000, 32'h0, 32'h0, 0, 99, 0);
    endtask

    task automatic test_backpressure();
        do_txn("out_stall", 1, 0, 2'b10, 0, 32'h0000_0200, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 5);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1; in_ren = 1; in_wen = 0; in_size = 2'b10; in_signed = 0;
        in_addr = 32'h0000_0040; in_wdata = 0; in_alu_result = 0;
        @(negedge clk);
        in_valid = 0;
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || mem_req_addr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_idle: got rdy=%b mv=%b a=%h want 1/0/0", in_ready, mem_req_valid, mem_req_addr);
        end
        mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
        @(negedge clk);
        mem_resp_valid = 0;
        repeat (2) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
                errors++;
                $display("[TB] FAIL stray_resp: got ov=%b rdy=%b d=%h want 0/1/0", out_valid, in_ready, out_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h7;
            do_txn($sformatf("rand%0d", i), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
                   1'($urandom), a, $urandom, $urandom, $urandom,
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_ren = 0; in_wen = 0; in_size = 0; in_signed = 0;
        in_addr = 0; in_wdata = 0; in_alu_result = 0; out_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        test_reset();
        test_directed();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter DATA_W, 32, data width in bits; legal values 32 or 64; STRB_W = DATA_W/8.
REQ-003 Parameter TIMEOUT, 255, maximum cycles spent in REQ+RESP before abort; 0 disables the timeout.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1 / in_ready  out  1  upstream (EXU) handshake.
REQ-008 in_ren, in_wen  in  1 each  load / store request; both 0 = pass-through.
REQ-009 in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-010 in_signed  in  1  sign-extend load result.
REQ-011 in_addr  in  ADDR_W  effective address.
REQ-012 in_wdata  in  DATA_W  store data, LSB-aligned.
REQ-013 in_alu_result  in  DATA_W  pass-through value.
REQ-014 out_valid  out  1 / out_ready  in  1  downstream (WBU) handshake.
REQ-015 out_data  out  DATA_W  load result, pass-through value, or 0.
REQ-016 out_err  out  1  misaligned, illegal-size or timeout.
REQ-017 mem_req_valid  out  1 / mem_req_ready  in  1  memory request handshake.
REQ-018 mem_req_we  out  1; mem_req_addr  out  ADDR_W; mem_req_wdata  out  DATA_W; mem_req_wstrb  out  STRB_W.
REQ-019 mem_resp_valid  in  1; mem_resp_data  in  DATA_W  memory response.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RESP, OUT; in_ready = (state==IDLE), mem_req_valid = (state==REQ), out_valid = (state==OUT).
REQ-021 On in_valid&in_ready all in_* fields SHALL be registered; no input is used after the accept cycle.
REQ-022 Accept with in_ren=in_wen=0 -> OUT, out_data=in_alu_result, out_err=0, no memory request.
REQ-023 Accept with in_ren or in_wen set, and either in_addr not a multiple of 2^in_size or (in_size==11 && DATA_W==32) -> OUT, out_err=1, out_data=0, no memory request.
REQ-024 in_ren and in_wen both 1 SHALL be treated as a store.
REQ-025 Otherwise accept -> REQ; mem_req_addr = in_addr with low log2(STRB_W) bits cleared; offset = those low bits.
REQ-026 Store: mem_req_we=1; wdata = in_wdata shifted left by offset*8; wstrb = (2^(2^size)-1) << offset. Load: we=0, wstrb=0, wdata=0.
REQ-027 mem_req_* SHALL stay stable while in REQ; mem_req_valid&mem_req_ready -> RESP.
REQ-028 mem_resp_valid SHALL be sampled only in RESP; outside RESP it is ignored.
REQ-029 In RESP on mem_resp_valid: load out_data = (mem_resp_data >> offset*8) truncated to 2^size bytes, sign-extended if in_signed else zero-extended; store out_data=0; out_err=0; -> OUT.
REQ-030 Timeout counter SHALL clear on accept and increment each cycle in REQ or RESP; when TIMEOUT!=0 and counter==TIMEOUT-1 without completing handshake -> OUT, out_err=1, out_data=0, mem_req_valid deasserts next cycle.
REQ-031 OUT: out_data/out_err stable until out_valid&out_ready, then -> IDLE; next accept no earlier than the following cycle.
REQ-032 Latency: pass-through/error accepted at t -> out_valid at t+1; zero-wait load/store accepted at t -> mem req handshake t+1, resp t+2, out_valid t+3.

Reset
REQ-033 rst SHALL force IDLE, in_ready=1 at the next edge, and out_valid=mem_req_valid=0, out_data=0, out_err=0, mem_req_*=0, counter=0.
REQ-034 Reset mid-transaction SHALL abandon it; a later stray mem_resp_valid SHALL be ignored.

Verification
REQ-035 Pass-through: in_alu_result=0x1234_5678, ren=wen=0, out_ready=1 -> out_valid 1 cycle after accept, out_data=0x1234_5678, no mem_req_valid.
REQ-036 Signed byte load DATA_W=32: addr=0x8000_0003, mem_resp_data=0x80AA_BBCC -> mem_req_addr=0x8000_0000, wstrb=0, out_data=0xFFFF_FF80; same with in_signed=0 -> 0x0000_0080.
REQ-037 Half store: addr=0x8000_0002, in_wdata=0x0000_BEEF -> mem_req_wdata=0xBEEF_0000, wstrb=0b1100, we=1, out_data=0.
REQ-038 Misaligned: word load at 0x8000_0001 -> out_err=1, out_data=0 at t+1, no mem_req_valid; double on DATA_W=32 -> same.
REQ-039 Backpressure/timeout TIMEOUT=4: mem_req_ready held 0 -> mem_req_valid for 4 cycles then out_err=1; separately out_ready held 0 for 5 cycles -> out_data stable, in_ready=0.
REQ-040 Reset in RESP, then mem_resp_valid pulse -> in IDLE, out_valid stays 0.
